// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-requester arbiter and access sequencer in front of a single-ported,
//   registered-output data memory. Requester A is the core load/store path,
//   requester B is the loader/debug path. Each access takes three cycles:
//   IDLE (grant), ACCESS (one enable cycle) and CAPTURE (read data returns).
//
// Handshake: a requester raises req with we/adr/wdata and holds req high until
//   it sees its done pulse. we/adr/wdata are sampled only on the grant edge.
//   done is a single-cycle pulse. err and rdata are valid while done is high.
//   rdata holds until that requester's next completion. A req that is still
//   high during its own done cycle is not treated as a new request.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   a_req/a_we/a_adr/a_wdata        requester A command
//   a_done/a_err/a_rdata            requester A completion
//   b_*                             same set for requester B
//   mem_adr/mem_wdata/mem_we/mem_re memory pins (registered)
//   mem_rdata                       memory read data, valid the cycle after mem_re
module dmem_arbiter #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_adr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_done,
  output logic          a_err,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_adr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_done,
  output logic          b_err,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  localparam logic [AW-1:0] DEPTH_LIMIT = AW'(DEPTH);

  // state is kept as a plain named register so checkers can bind to it.
  logic [1:0] state;
  logic       lastGrantB;  // 1: B was granted most recently
  logic       winB;        // owner of the access in flight
  logic       errFlag;     // access in flight is out of range
  logic       isRead;      // access in flight is a read

  logic          aElig;
  logic          bElig;
  logic          grantB;
  logic          selWe;
  logic [AW-1:0] selAdr;
  logic [DW-1:0] selWdata;
  logic          selInRange;

  // A requester whose done is high this cycle is still holding req from the
  // access just finished, so it is not eligible again until the next cycle.
  assign aElig = a_req & ~a_done;
  assign bElig = b_req & ~b_done;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    grantB = 1'b0;
    if (aElig && bElig) grantB = ~lastGrantB;
    else                grantB = bElig;
  end

  assign selWe      = grantB ? b_we    : a_we;
  assign selAdr     = grantB ? b_adr   : a_adr;
  assign selWdata   = grantB ? b_wdata : a_wdata;
  assign selInRange = (selAdr < DEPTH_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      lastGrantB <= 1'b1;
      winB       <= 1'b0;
      errFlag    <= 1'b0;
      isRead     <= 1'b0;
      a_done     <= 1'b0;
      a_err      <= 1'b0;
      a_rdata    <= '0;
      b_done     <= 1'b0;
      b_err      <= 1'b0;
      b_rdata    <= '0;
      mem_adr    <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
    end else begin
      a_done <= 1'b0;
      b_done <= 1'b0;
      case (state)
        IDLE: begin
          if (aElig || bElig) begin
            winB       <= grantB;
            lastGrantB <= grantB;
            mem_adr    <= selAdr;
            mem_wdata  <= selWdata;
            isRead     <= ~selWe;
            // Out-of-range accesses still walk the FSM so completion timing
            // is identical, but never touch the memory pins' enables.
            if (selInRange) begin
              mem_we  <= selWe;
              mem_re  <= ~selWe;
              errFlag <= 1'b0;
            end else begin
              mem_we  <= 1'b0;
              mem_re  <= 1'b0;
              errFlag <= 1'b1;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          // Memory samples its pins at the end of this cycle.
          mem_we <= 1'b0;
          mem_re <= 1'b0;
          state  <= CAPTURE;
        end
        CAPTURE: begin
          if (winB) begin
            b_done  <= 1'b1;
            b_err   <= errFlag;
            b_rdata <= (isRead && !errFlag) ? mem_rdata : '0;
          end else begin
            a_done  <= 1'b1;
            a_err   <= errFlag;
            a_rdata <= (isRead && !errFlag) ? mem_rdata : '0;
          end
          state <= IDLE;
        end
        default: begin
          mem_we <= 1'b0;
          mem_re <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_adr, a_wdata, b_adr, b_wdata;
  logic        a_done, a_err, b_done, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_adr, mem_wdata;
  logic        mem_we, mem_re;
  logic [31:0] mem_rdata = '0;
  logic [31:0] tbMem [0:7] = '{default: 32'h0};

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.DW(32), .AW(32), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_wdata(a_wdata),
    .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_wdata(b_wdata),
    .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model: registered read ----------------
  always @(posedge clk) begin
    if (mem_we && mem_adr < 32'd8) tbMem[mem_adr[2:0]] <= mem_wdata;
    if (mem_re && mem_adr < 32'd8) mem_rdata <= tbMem[mem_adr[2:0]];
  end

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver: one transaction from an idle arbiter ----------------
  task automatic doTxn(input logic isB, input logic we, input logic [31:0] adr,
                       input logic [31:0] wdata, output int lat, output logic err,
                       output logic [31:0] rdata, output int enCnt,
                       output logic [31:0] enAdr);
    bit seen;
    seen = 0; lat = -1; err = 1'bx; rdata = 'x; enCnt = 0; enAdr = '0;
    if (isB) begin b_we = we; b_adr = adr; b_wdata = wdata; b_req = 1'b1; end
    else     begin a_we = we; a_adr = adr; a_wdata = wdata; a_req = 1'b1; end
    for (int i = 1; i <= 12 && !seen; i++) begin
      tick();
      if (mem_we || mem_re) begin enCnt++; enAdr = mem_adr; end
      if (isB ? b_done : a_done) begin
        seen  = 1;
        lat   = i;
        err   = isB ? b_err : a_err;
        rdata = isB ? b_rdata : a_rdata;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  // ---------------- multi-requester watcher: logs completions in order ----------------
  int          evId[$];
  int          evT[$];
  logic [31:0] evData[$];

  task automatic watch(input int nA, input int nB, input int maxCyc, input int bRaiseAt);
    int cntA, cntB;
    cntA = 0; cntB = 0;
    evId.delete(); evT.delete(); evData.delete();
    for (int t = 1; t <= maxCyc && (cntA < nA || cntB < nB); t++) begin
      tick();
      if (a_done) begin
        evId.push_back(0); evT.push_back(t); evData.push_back(a_rdata);
        cntA++;
        if (cntA == nA) a_req = 1'b0;
      end
      if (b_done) begin
        evId.push_back(1); evT.push_back(t); evData.push_back(b_rdata);
        cntB++;
        if (cntB == nB) b_req = 1'b0;
      end
      if (t == bRaiseAt) b_req = 1'b1;
    end
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_flags"}, {58'd0, a_done, a_err, b_done, b_err, mem_we, mem_re}, 64'd0);
    check({tag, "_rdata"}, {a_rdata, b_rdata}, 64'd0);
    check({tag, "_mem"}, {mem_adr, mem_wdata}, 64'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        isB;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        expErr;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int          lat, enCnt, expIds[5], expTs[5];
    logic        err;
    logic [31:0] rdata, enAdr;
    logic [31:0] expQ[$];
    bit          sawDone;

    vecs[0]  = '{1'b0, 1'b1, 32'd3,          32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'd3,          32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b1, 32'd5,          32'h12345678, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'd5,          32'h0,        1'b0, 32'h12345678};
    vecs[4]  = '{1'b1, 1'b0, 32'd3,          32'h0,        1'b0, 32'hDEADBEEF};
    vecs[5]  = '{1'b1, 1'b0, 32'd8,          32'h0,        1'b1, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'hFFFFFFFF,   32'h0,        1'b1, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 32'd7,          32'hA5A5A5A5, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'd7,          32'h0,        1'b0, 32'hA5A5A5A5};
    vecs[9]  = '{1'b0, 1'b0, 32'd7,          32'h0,        1'b0, 32'hA5A5A5A5};
    vecs[10] = '{1'b0, 1'b1, 32'd9,          32'hCAFEF00D, 1'b1, 32'h0};

    // ---- reset ----
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_adr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_adr = 0; b_wdata = 0;
    tick(); tick();
    checkReset("reset");
    rst_n = 1'b1;
    tick();

    // ---- table-driven single transactions ----
    for (int i = 0; i < 11; i++) begin
      doTxn(vecs[i].isB, vecs[i].we, vecs[i].adr, vecs[i].wdata, lat, err, rdata, enCnt, enAdr);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd3);
      check($sformatf("v%0d_err", i), {63'd0, err}, {63'd0, vecs[i].expErr});
      check($sformatf("v%0d_rdata", i), {32'd0, rdata}, {32'd0, vecs[i].expRdata});
      check($sformatf("v%0d_enables", i), 64'(enCnt), vecs[i].expErr ? 64'd0 : 64'd1);
      if (!vecs[i].expErr) check($sformatf("v%0d_mem_adr", i), {32'd0, enAdr}, {32'd0, vecs[i].adr});
      tick();
      check($sformatf("v%0d_done_pulse", i), {62'd0, a_done, b_done}, 64'd0);
    end

    // ---- tie after reset: A wins first ----
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    a_we = 0; a_adr = 1; b_we = 1; b_adr = 1; b_wdata = 32'h55;
    a_req = 1; b_req = 1;
    watch(1, 1, 20, 0);
    check("tie1_count", 64'(evId.size()), 64'd2);
    if (evId.size() == 2) begin
      check("tie1_order", {32'(evId[0]), 32'(evId[1])}, {32'd0, 32'd1});
      check("tie1_times", {32'(evT[0]), 32'(evT[1])}, {32'd3, 32'd6});
      check("tie1_a_old_data", {32'd0, evData[0]}, 64'd0);
    end
    tick();
    doTxn(1'b0, 1'b0, 32'd1, 32'd0, lat, err, rdata, enCnt, enAdr);
    check("tie1_readback", {32'd0, rdata}, 64'h55);
    tick();

    // ---- second tie: A was granted last, so B goes first ----
    a_we = 0; a_adr = 1; b_we = 1; b_adr = 1; b_wdata = 32'h77;
    a_req = 1; b_req = 1;
    watch(1, 1, 20, 0);
    check("tie2_count", 64'(evId.size()), 64'd2);
    if (evId.size() == 2) begin
      check("tie2_order", {32'(evId[0]), 32'(evId[1])}, {32'd1, 32'd0});
      check("tie2_times", {32'(evT[0]), 32'(evT[1])}, {32'd3, 32'd6});
      check("tie2_a_new_data", {32'd0, evData[1]}, 64'h77);
    end
    tick();

    // ---- A holds req for 4 reads, B requests once ----
    a_we = 0; a_adr = 3; b_we = 0; b_adr = 7;
    a_req = 1;
    watch(4, 1, 40, 1);
    expIds = '{0, 1, 0, 0, 0};
    expTs  = '{3, 6, 9, 13, 17};
    expQ   = '{32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    check("hold_count", 64'(evId.size()), 64'd5);
    if (evId.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("hold%0d_id", i), 64'(evId[i]), 64'(expIds[i]));
        check($sformatf("hold%0d_time", i), 64'(evT[i]), 64'(expTs[i]));
        check($sformatf("hold%0d_data", i), {32'd0, evData[i]}, {32'd0, expQ.pop_front()});
      end
    end
    tick();

    // ---- reset during ACCESS of an A read ----
    a_we = 0; a_adr = 3; a_req = 1;
    tick();
    check("rst_access_re", {63'd0, mem_re}, 64'd1);
    rst_n = 1'b0;
    tick();
    checkReset("rst_mid");
    rst_n = 1'b1; a_req = 0;
    sawDone = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (a_done) sawDone = 1;
    end
    check("rst_no_done", {63'd0, sawDone}, 64'd0);
    doTxn(1'b0, 1'b0, 32'd3, 32'd0, lat, err, rdata, enCnt, enAdr);
    check("rst_after_lat", 64'(lat), 64'd3);
    check("rst_after_rdata", {32'd0, rdata}, 64'hDEADBEEF);
    tick();

    // ---- inputs changed after grant are ignored ----
    a_we = 1; a_adr = 2; a_wdata = 32'h11111111; a_req = 1;
    tick();
    check("chg_grant_pins", {30'd0, mem_we, mem_re, mem_adr}, {30'd0, 2'b10, 32'd2});
    a_adr = 4; a_wdata = 32'h22222222;
    tick();
    check("chg_access_pins", {mem_adr, mem_wdata}, {32'd2, 32'h11111111});
    check("chg_enable_off", {62'd0, mem_we, mem_re}, 64'd0);
    tick();
    check("chg_done", {63'd0, a_done}, 64'd1);
    a_req = 0;
    check("chg_mem2", {32'd0, tbMem[2]}, 64'h11111111);
    check("chg_mem4", {32'd0, tbMem[4]}, 64'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of the single-ported data memory.
- Requester A is the core load/store path; requester B is the loader/debug path.
- Serialises requests, drives the memory's address, write-data, write-enable and read-enable pins, and captures the registered memory read data.
- Returns completion, read data and an address-range error to the winning requester. Round-robin fairness on contention.

Parameters:
- DW, 32, data width in bits.
- AW, 32, address width in bits (word address).
- DEPTH, 8, number of words in the attached memory; addresses >= DEPTH are out of range.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- a_req  in  1  A request; held high until a_done.
- a_we  in  1  A op: 1 = write, 0 = read.
- a_adr  in  AW  A word address.
- a_wdata  in  DW  A write data.
- a_done  out  1  A completion pulse.
- a_err  out  1  A out-of-range flag; valid with a_done.
- a_rdata  out  DW  A read data; valid with a_done.
- b_req, b_we, b_adr, b_wdata, b_done, b_err, b_rdata: same as A, for requester B.
- mem_adr  out  AW  to memory address pin.
- mem_wdata  out  DW  to memory write-data pin.
- mem_we  out  1  to memory write pin.
- mem_re  out  1  to memory read pin.
- mem_rdata  in  DW  from memory read output; registered by memory, valid the cycle after it samples mem_re.

Behaviour:
- All outputs are registered.
- Reset values:
  - all done/err = 0; all rdata = 0.
  - mem_we = mem_re = 0; mem_adr = mem_wdata = 0.
  - FSM = IDLE; last_grant = B, so A wins the first tie.
- FSM IDLE:
  - A request is eligible if req = 1 and that requester's done is not high this cycle.
  - Requests in the done cycle are ignored, so a held req is not re-served.
  - None eligible: stay IDLE.
  - One eligible: grant it.
  - Both eligible: grant the one that is not last_grant.
  - On grant:
    - latch the winner id and update last_grant.
    - mem_adr <= adr; mem_wdata <= wdata.
    - If adr < DEPTH: mem_we <= we, mem_re <= ~we, go ACCESS.
    - If adr >= DEPTH: mem_we = mem_re = 0, go ACCESS with the error flag set.
- FSM ACCESS:
  - Memory samples its pins at the end of this cycle.
  - Next state CAPTURE; mem_we <= 0, mem_re <= 0. Exactly one enable cycle per access.
- FSM CAPTURE:
  - mem_rdata is valid this cycle.
  - Winner's done <= 1.
  - Winner's rdata <= mem_rdata for an in-range read; 0 for writes and errors.
  - err <= error flag.
  - Go IDLE.
- Done is high for exactly one cycle (the IDLE cycle that follows CAPTURE), then cleared. rdata holds until that requester's next completion.
- Latency: req sampled at edge k (IDLE) → mem enable high in cycle k+1 → done high in cycle k+3. Maximum throughput is one access per 3 cycles.
- Non-winner req is held and served next; no starvation. Worst-case wait is one foreign access plus its own.
- Request inputs (we, adr, wdata) are sampled only at grant. Changes while pending or in progress are ignored.
- Dropping req before done is illegal. The access still completes and done still pulses.
- A write followed by a read of the same address in back-to-back grants returns the new data.
- rst_n low at any state: next edge forces the reset values, FSM IDLE, no done issued. A write whose enable was already sampled by memory is not rolled back.
- Address comparison is unsigned over the full AW bits.

Test Plan:
- Reset, then A writes 0xDEADBEEF to adr 3 → mem_we high exactly one cycle with mem_adr = 3; a_done in cycle k+3, a_err = 0. A then reads adr 3 → a_rdata = 0xDEADBEEF with a_done at k+3.
- A and B both request at the same cycle after reset (A read adr 1, B write 0x55 to adr 1) → A granted first (old data), then B. Repeat the tie → B granted first (round-robin). A subsequent read of adr 1 returns 0x55.
- A holds req continuously for 4 reads while B requests once → grants alternate A,B,A,A,A. A is not re-served in its own done cycle; no back-to-back duplicate grant.
- B reads adr 8 and then adr 0xFFFFFFFF → mem_re/mem_we stay 0 throughout; b_done with b_err = 1 and b_rdata = 0.
- rst_n low during ACCESS of an A read → next cycle all outputs at reset values, a_done never pulses. After release, a new A read completes normally.
- A write with a_adr/a_wdata changed in the cycle after grant → memory receives the values sampled at grant.
